// File: rtl/csi2_pkt_ctrl.sv
// csi2_pkt_ctrl: CSI-2 packet sequencer that qualifies headers, strips CRC and emits payload
// with byte enables or sync pulses, and closes each packet with pkt_done_o.
module csi2_pkt_ctrl #(
   parameter bit          VC_FILTER_EN = 1'b1,
   parameter logic [1:0]  ACCEPT_VC    = 2'd0,
   parameter logic [15:0] MAX_WC       = 16'd8192
) (
   input  logic        clk_i,
   input  logic        srst_i,
   input  logic        valid_i,
   input  logic [31:0] data_i,
   input  logic        error_i,
   input  logic        error_corrected_i,
   output logic        pkt_done_o,
   output logic        frame_start_o,
   output logic        frame_end_o,
   output logic        line_start_o,
   output logic        line_end_o,
   output logic [15:0] short_data_o,
   output logic [1:0]  vc_o,
   output logic [5:0]  dt_o,
   output logic [31:0] payload_o,
   output logic        payload_valid_o,
   output logic [3:0]  payload_keep_o,
   output logic        payload_last_o,
   output logic        payload_sof_o,
   output logic [15:0] hdr_err_cnt_o,
   output logic [15:0] hdr_corr_cnt_o
);
   typedef enum logic [1:0] {IDLE, PAYLOAD, WAIT_GAP} state_t;
   state_t state, state_n;
   logic [15:0] wc, idx;
   logic [16:0] nw;
   logic filtered, sof;
   logic hdr, word, is_long, bad, last_word, emit;
   logic [5:0] h_dt;
   logic [15:0] h_wc;
   logic [1:0] h_vc;
   logic signed [17:0] rem;
   logic [3:0] keep;
   assign h_dt = data_i[5:0];
   assign h_vc = data_i[7:6];
   assign h_wc = data_i[23:8];
   assign hdr = state == IDLE && valid_i;
   assign word = state == PAYLOAD && valid_i;
   assign is_long = h_dt >= 6'h10;
   assign bad = (error_i && !error_corrected_i) || (is_long && h_wc > MAX_WC);
   // Bytes still owed to the payload before this word; zero or below means CRC only.
   assign rem = $signed({2'b00, wc}) - $signed({idx, 2'b00});
   assign keep = rem >= 18'sd4 ? 4'hF : rem == 18'sd3 ? 4'h7 : rem == 18'sd2 ? 4'h3 :
                 rem == 18'sd1 ? 4'h1 : 4'h0;
   assign last_word = {1'b0, idx} == nw - 17'd1;
   assign emit = keep != 4'h0 && !filtered;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:     state_n = valid_i ? ((bad || !is_long) ? WAIT_GAP : PAYLOAD) : IDLE;
         PAYLOAD:  state_n = (word && last_word) ? WAIT_GAP : PAYLOAD;
         WAIT_GAP: state_n = valid_i ? WAIT_GAP : IDLE;
         default:  state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) state <= IDLE;
      else state <= state_n;
   end
   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         pkt_done_o      <= 1'b0;
         frame_start_o   <= 1'b0;
         frame_end_o     <= 1'b0;
         line_start_o    <= 1'b0;
         line_end_o      <= 1'b0;
         short_data_o    <= '0;
         vc_o            <= '0;
         dt_o            <= '0;
         payload_o       <= '0;
         payload_valid_o <= 1'b0;
         payload_keep_o  <= '0;
         payload_last_o  <= 1'b0;
         payload_sof_o   <= 1'b0;
         hdr_err_cnt_o   <= '0;
         hdr_corr_cnt_o  <= '0;
         wc              <= '0;
         idx             <= '0;
         nw              <= '0;
         filtered        <= 1'b0;
         sof             <= 1'b0;
      end else begin
         pkt_done_o      <= 1'b0;
         frame_start_o   <= 1'b0;
         frame_end_o     <= 1'b0;
         line_start_o    <= 1'b0;
         line_end_o      <= 1'b0;
         payload_valid_o <= 1'b0;
         payload_keep_o  <= '0;
         payload_last_o  <= 1'b0;
         payload_sof_o   <= 1'b0;
         if (hdr) begin
            vc_o     <= h_vc;
            dt_o     <= h_dt;
            wc       <= h_wc;
            nw       <= ({1'b0, h_wc} + 17'd5) >> 2;
            idx      <= '0;
            filtered <= VC_FILTER_EN && h_vc != ACCEPT_VC;
            if (bad) begin
               pkt_done_o    <= 1'b1;
               hdr_err_cnt_o <= hdr_err_cnt_o == 16'hFFFF ? hdr_err_cnt_o : hdr_err_cnt_o + 16'd1;
            end else begin
               if (error_i)
                  hdr_corr_cnt_o <= hdr_corr_cnt_o == 16'hFFFF ? hdr_corr_cnt_o : hdr_corr_cnt_o + 16'd1;
               if (!is_long) begin
                  short_data_o  <= h_wc;
                  pkt_done_o    <= 1'b1;
                  frame_start_o <= h_dt == 6'h00;
                  frame_end_o   <= h_dt == 6'h01;
                  line_start_o  <= h_dt == 6'h02;
                  line_end_o    <= h_dt == 6'h03;
                  if (h_dt == 6'h00) sof <= 1'b1;
                  if (h_dt == 6'h01) sof <= 1'b0;
               end
            end
         end
         if (word) begin
            idx             <= idx + 16'd1;
            payload_o       <= data_i;
            payload_keep_o  <= keep;
            payload_valid_o <= emit;
            payload_last_o  <= keep != 4'h0 && rem <= 18'sd4;
            payload_sof_o   <= sof && emit;
            pkt_done_o      <= last_word;
            if (emit) sof <= 1'b0;
         end
      end
   end
endmodule
